uart_reg_ctrl: RTL and testbench
================================

UART_REG_CTRL -- requirements
Module: uart_reg_ctrl

Interface
REQ-001 Parameter N_REGS, default 8: number of addressable registers; valid addresses are 0..N_REGS-1.
REQ-002 Parameter TIMEOUT_CLKS, default 5680: clocks allowed between a write command byte and its data byte.
REQ-003 Parameter EVT_BYTE, default 8'hE5: byte sent on a code-phase event.
REQ-004 clk_in  input  1  single system clock; all logic is clocked on its rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 rx_valid_in  input  1  one-cycle pulse: rx_data_in holds a received byte.
REQ-007 rx_data_in  input  8  received byte.
REQ-008 reg_wr_out  output  1  one-cycle register write strobe.
REQ-009 reg_rd_out  output  1  one-cycle register read strobe.
REQ-010 reg_addr_out  output  3  register address; valid while reg_wr_out or reg_rd_out is high.
REQ-011 reg_wdata_out  output  8  write data; valid with reg_wr_out.
REQ-012 reg_rdata_in  input  8  read data; valid exactly one cycle after reg_rd_out.
REQ-013 tx_start_out  output  1  one-cycle pulse requesting transmission of tx_data_out.
REQ-014 tx_data_out  output  8  byte to transmit; held stable from tx_start_out until return to IDLE.
REQ-015 tx_busy_in  input  1  transmitter busy.
REQ-016 code_phase_done_in  input  1  event pulse from the code generator.
REQ-017 rx_drop_out  output  1  one-cycle pulse: a received byte was discarded.
REQ-018 timeout_out  output  1  one-cycle pulse: a pending write was abandoned.

Function
REQ-019 Command byte: bit7 is rw (1 = read), bits6:0 are the address.
REQ-020 The FSM SHALL implement the states IDLE, WAIT_DATA, RD_STROBE, RD_CAPT, TX_REQ and TX_WAIT.
REQ-021 IDLE with rx_valid_in and rw=0: the FSM latches the address, clears the timeout counter and goes to WAIT_DATA.
REQ-022 WAIT_DATA with rx_valid_in: the FSM asserts reg_wr_out with the latched address and data in the next cycle, then returns to IDLE.
REQ-023 WAIT_DATA: when the counter reaches TIMEOUT_CLKS-1 without a byte, the FSM pulses timeout_out, performs no write and returns to IDLE.
REQ-024 IDLE with rx_valid_in and rw=1: the FSM goes to RD_STROBE and asserts reg_rd_out for one cycle, then goes to RD_CAPT.
REQ-025 RD_CAPT: the FSM captures reg_rdata_in into tx_data_out and goes to TX_REQ.
REQ-026 Out-of-range address (>= N_REGS): a write is silently dropped without a strobe; a read sends 8'h00 without asserting reg_rd_out.
REQ-027 TX_REQ: the FSM waits while tx_busy_in=1, pulses tx_start_out in the first cycle with tx_busy_in=0, and enters TX_WAIT.
REQ-028 TX_WAIT: the FSM ignores tx_busy_in in the first cycle, then returns to IDLE in the first cycle with tx_busy_in=0.
REQ-029 rx_valid_in in any state other than IDLE or WAIT_DATA: the byte is discarded and rx_drop_out pulses in the next cycle.
REQ-030 Read-response latency: tx_start_out occurs no earlier than 3 cycles after the command rx_valid_in.
REQ-031 reg_wr_out and reg_rd_out SHALL never be high in the same cycle.

Reset
REQ-032 rst_in=1 SHALL force the FSM to IDLE, clear all strobes and pulses, clear tx_data_out to 8'h00, clear the timeout counter and clear the event-pending flag.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no strobe and no tx_start_out.

Configuration
REQ-034 Macro EVENT_NOTIFY_EN defined: code_phase_done_in sets a pending flag.
REQ-035 Coalescing: multiple events arriving while the flag is pending coalesce into one.
REQ-036 Event send: in IDLE with the flag set and no rx_valid_in, the FSM loads EVT_BYTE, clears the flag and goes to TX_REQ.
REQ-037 Arbitration: rx_valid_in in IDLE has priority over a pending event; the event waits.
REQ-038 Simultaneous event and flag clear: an event arriving in the same cycle the flag is cleared re-sets the flag.
REQ-039 Macro EVENT_NOTIFY_EN undefined: code_phase_done_in is ignored and no event byte is ever sent.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding, the RW bit index and the EVT_BYTE default.
REQ-041 The timeout counter is a single sub-module, uart_reg_timeout, with clear, enable and expired signals.

Verification
REQ-042 Write: bytes 8'h03 then 8'h5A -> exactly one reg_wr_out, with addr 3 and wdata 8'h5A.
REQ-043 Read: byte 8'h85 with reg_rdata_in=8'hBA -> one reg_rd_out with addr 5, then tx_start_out with tx_data_out=8'hBA.
REQ-044 Timeout: byte 8'h02 followed by silence for TIMEOUT_CLKS cycles -> timeout_out pulse and no reg_wr_out.
REQ-045 Overrun: a byte arrives during TX_WAIT with tx_busy_in=1 -> rx_drop_out pulse and no register strobe.
REQ-046 Event (EVENT_NOTIFY_EN defined): three code_phase_done_in pulses during a read response -> the read byte is sent first, then exactly one 8'hE5.
REQ-047 Out of range: read command 8'h8A -> no reg_rd_out and tx_data_out=8'h00; write 8'h0A,8'h11 -> no reg_wr_out.

Source files
------------

// File: rtl/uart_reg_ctrl_pkg.sv
// uart_reg_ctrl_pkg
// Shared definitions for the UART register controller: FSM state encoding,
// command byte layout, default event byte and an address range helper.
// No ports.

package uart_reg_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_RD_STROBE,
        ST_RD_CAPT,
        ST_TX_REQ,
        ST_TX_WAIT
    } state_t;

    // Command byte: bit 7 selects read (1) or write (0), bits 6:0 are the address
    localparam int RW_BIT = 7;

    // Width of the register address presented on the register bus
    localparam int ADDR_W = 3;

    // Byte transmitted when a code-phase event is reported
    localparam logic [7:0] EVT_BYTE_DEFAULT = 8'hE5;

    // True when a 7-bit command address selects an existing register
    function automatic logic addr_in_range(input logic [6:0] addr, input int n_regs);
        return int'(addr) < n_regs;
    endfunction

endpackage

// File: rtl/uart_reg_ctrl_if.sv
// uart_reg_ctrl_if
// Bundles the UART receive/transmit handshake, the register bus and the
// code-phase event input of the UART register controller.
// Signals:
//   rx_valid_in, rx_data_in      received byte pulse and data
//   reg_wr_out, reg_rd_out       register write / read strobes
//   reg_addr_out, reg_wdata_out  register address and write data
//   reg_rdata_in                 register read data (one cycle after reg_rd_out)
//   tx_start_out, tx_data_out    transmit request pulse and byte
//   tx_busy_in                   transmitter busy
//   code_phase_done_in           code generator event pulse
//   rx_drop_out, timeout_out     discarded byte / abandoned write pulses
// Modports:
//   master  the controller side
//   slave   the UART, register file and event source side

interface uart_reg_ctrl_if;
    import uart_reg_ctrl_pkg::*;

    logic              rx_valid_in;
    logic [7:0]        rx_data_in;
    logic              reg_wr_out;
    logic              reg_rd_out;
    logic [ADDR_W-1:0] reg_addr_out;
    logic [7:0]        reg_wdata_out;
    logic [7:0]        reg_rdata_in;
    logic              tx_start_out;
    logic [7:0]        tx_data_out;
    logic              tx_busy_in;
    logic              code_phase_done_in;
    logic              rx_drop_out;
    logic              timeout_out;

    modport master (
        input  rx_valid_in, rx_data_in, reg_rdata_in, tx_busy_in, code_phase_done_in,
        output reg_wr_out, reg_rd_out, reg_addr_out, reg_wdata_out,
               tx_start_out, tx_data_out, rx_drop_out, timeout_out
    );

    modport slave (
        output rx_valid_in, rx_data_in, reg_rdata_in, tx_busy_in, code_phase_done_in,
        input  reg_wr_out, reg_rd_out, reg_addr_out, reg_wdata_out,
               tx_start_out, tx_data_out, rx_drop_out, timeout_out
    );

endinterface

// File: rtl/uart_reg_timeout.sv
// uart_reg_timeout
// Counts clocks while a write command waits for its data byte.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   clear    restart the count from zero
//   enable   advance the count by one this clock
//   expired  high while the count equals TIMEOUT_CLKS-1
// The count saturates at the expiry value so expired stays high until cleared.

module uart_reg_timeout #(
    parameter int TIMEOUT_CLKS = 5680
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl
// Decodes command bytes received over a UART into register writes and reads,
// and returns read data (or an event notification byte) to the transmitter.
// Ports:
//   clk_in   system clock, rising edge
//   rst_in   synchronous active-high reset
//   bus      uart_reg_ctrl_if.master: UART rx/tx handshake, register bus,
//            code-phase event input, drop and timeout pulses
// Parameters:
//   N_REGS        number of registers (valid addresses 0..N_REGS-1)
//   TIMEOUT_CLKS  clocks allowed between a write command and its data byte
//   EVT_BYTE      byte sent when a code-phase event is reported
// Build option:
//   EVENT_NOTIFY_EN  when defined, code_phase_done_in events are queued in a
//                    single pending flag and reported by sending EVT_BYTE.
//                    When undefined the event input is ignored.

module uart_reg_ctrl
    import uart_reg_ctrl_pkg::*;
#(
    parameter int         N_REGS       = 8,
    parameter int         TIMEOUT_CLKS = 5680,
    parameter logic [7:0] EVT_BYTE     = EVT_BYTE_DEFAULT
) (
    input logic             clk_in,
    input logic             rst_in,
    uart_reg_ctrl_if.master bus
);

    state_t     state;
    logic       in_range;
    logic       tx_first;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_expired;
    logic       evt_take;
    logic       rx_rw;
    logic [6:0] rx_addr;
    logic       cmd_in_range;

    assign rx_rw        = bus.rx_data_in[RW_BIT];
    assign rx_addr      = bus.rx_data_in[6:0];
    assign cmd_in_range = addr_in_range(rx_addr, N_REGS);

    // The counter only runs while a write waits for data and restarts
    // whenever the controller is anywhere else.
    assign tmo_clear  = (state != ST_WAIT_DATA);
    assign tmo_enable = (state == ST_WAIT_DATA);

    uart_reg_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk     (clk_in),
        .rst     (rst_in),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

`ifdef EVENT_NOTIFY_EN
    logic evt_pending;

    // A received byte in IDLE wins over a pending event; the event then
    // waits for the next idle cycle without traffic.
    assign evt_take = (state == ST_IDLE) && evt_pending && !bus.rx_valid_in;

    // Events coalesce into one flag. An event arriving in the same cycle the
    // flag is consumed sets it again so it is not lost.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            evt_pending <= 1'b0;
        end else begin
            evt_pending <= bus.code_phase_done_in || (evt_pending && !evt_take);
        end
    end
`else
    logic unused_evt_in;

    assign unused_evt_in = bus.code_phase_done_in;
    assign evt_take      = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= ST_IDLE;
            in_range          <= 1'b0;
            tx_first          <= 1'b0;
            bus.reg_wr_out    <= 1'b0;
            bus.reg_rd_out    <= 1'b0;
            bus.reg_addr_out  <= '0;
            bus.reg_wdata_out <= 8'h00;
            bus.tx_start_out  <= 1'b0;
            bus.tx_data_out   <= 8'h00;
            bus.rx_drop_out   <= 1'b0;
            bus.timeout_out   <= 1'b0;
        end else begin
            bus.reg_wr_out   <= 1'b0;
            bus.reg_rd_out   <= 1'b0;
            bus.tx_start_out <= 1'b0;
            bus.rx_drop_out  <= 1'b0;
            bus.timeout_out  <= 1'b0;

            // Only IDLE and WAIT_DATA consume bytes; anything else overruns
            if (bus.rx_valid_in && (state != ST_IDLE) && (state != ST_WAIT_DATA)) begin
                bus.rx_drop_out <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.rx_valid_in) begin
                        bus.reg_addr_out <= rx_addr[ADDR_W-1:0];
                        in_range         <= cmd_in_range;
                        if (rx_rw) begin
                            // Out-of-range reads still answer, just without a strobe
                            bus.reg_rd_out <= cmd_in_range;
                            state          <= ST_RD_STROBE;
                        end else begin
                            state <= ST_WAIT_DATA;
                        end
                    end else if (evt_take) begin
                        bus.tx_data_out <= EVT_BYTE;
                        state           <= ST_TX_REQ;
                    end
                end

                ST_WAIT_DATA: begin
                    if (bus.rx_valid_in) begin
                        bus.reg_wr_out    <= in_range;
                        bus.reg_wdata_out <= bus.rx_data_in;
                        state             <= ST_IDLE;
                    end else if (tmo_expired) begin
                        bus.timeout_out <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end

                ST_RD_STROBE: begin
                    state <= ST_RD_CAPT;
                end

                ST_RD_CAPT: begin
                    bus.tx_data_out <= in_range ? bus.reg_rdata_in : 8'h00;
                    state           <= ST_TX_REQ;
                end

                ST_TX_REQ: begin
                    if (!bus.tx_busy_in) begin
                        bus.tx_start_out <= 1'b1;
                        tx_first         <= 1'b1;
                        state            <= ST_TX_WAIT;
                    end
                end

                ST_TX_WAIT: begin
                    // The transmitter cannot report busy in the cycle it sees
                    // tx_start, so the first cycle here ignores tx_busy_in.
                    if (tx_first) begin
                        tx_first <= 1'b0;
                    end else if (!bus.tx_busy_in) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb_uart_reg_ctrl
// Self-checking bench for uart_reg_ctrl. Directed scenarios are followed by
// random register transactions; a transaction-level model (expected register
// contents, expected strobe/byte counts) predicts every observed result.

module tb_uart_reg_ctrl;
    import uart_reg_ctrl_pkg::*;

    localparam int TB_TIMEOUT = 24;
    localparam int SETTLE     = 16;

    logic clk_in = 1'b0;
    logic rst_in;

    uart_reg_ctrl_if bus ();

    uart_reg_ctrl #(
        .N_REGS       (8),
        .TIMEOUT_CLKS (TB_TIMEOUT),
        .EVT_BYTE     (8'hE5)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: observed activity, sampled mid-cycle
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         drop_cnt = 0;
    int         to_cnt = 0;
    int         tx_cnt = 0;
    int         both_cnt = 0;
    int         last_tx_cyc = 0;
    logic [2:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;
    logic [2:0] last_rd_addr = '0;
    logic [7:0] last_tx_byte = '0;
    logic [7:0] prev_tx_byte = '0;
    logic [7:0] env_mem [8] = '{default: 8'h00};

    always @(negedge clk_in) begin
        if (bus.reg_wr_out === 1'b1 && bus.reg_rd_out === 1'b1) both_cnt++;
        if (bus.reg_wr_out === 1'b1) begin
            wr_cnt++;
            last_wr_addr = bus.reg_addr_out;
            last_wr_data = bus.reg_wdata_out;
            env_mem[bus.reg_addr_out] = bus.reg_wdata_out;
        end
        if (bus.reg_rd_out === 1'b1) begin
            rd_cnt++;
            last_rd_addr = bus.reg_addr_out;
        end
        if (bus.tx_start_out === 1'b1) begin
            tx_cnt++;
            prev_tx_byte = last_tx_byte;
            last_tx_byte = bus.tx_data_out;
            last_tx_cyc  = cyc;
        end
        if (bus.rx_drop_out === 1'b1) drop_cnt++;
        if (bus.timeout_out === 1'b1) to_cnt++;
    end

    // Environment: register file read port and transmitter busy behaviour
    int   rd_served = 0;
    int   tx_served = 0;
    int   busy_left = 0;
    int   busy_len = 0;
    logic force_busy = 1'b0;

    always @(posedge clk_in) begin
        #1;
        if (rd_cnt != rd_served) begin
            bus.reg_rdata_in = env_mem[last_rd_addr];
            rd_served = rd_cnt;
        end else begin
            bus.reg_rdata_in = 8'($urandom);
        end
        if (tx_cnt != tx_served) begin
            busy_left = (busy_len > 0) ? busy_len : int'($urandom_range(1, 4));
            tx_served = tx_cnt;
        end
        bus.tx_busy_in = force_busy || (busy_left > 0);
        if (busy_left > 0) busy_left--;
    end

    // Reference model state
    logic [7:0] exp_mem [8] = '{default: 8'h00};
    int exp_wr = 0;
    int exp_rd = 0;
    int exp_to = 0;
    int exp_drop = 0;
    int exp_tx = 0;
    int cmd_cyc = 0;
    int checks = 0;
    int errors = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_valid_in = 1'b1;
        bus.rx_data_in  = b;
        cmd_cyc = cyc;
        step(1);
        bus.rx_valid_in = 1'b0;
        bus.rx_data_in  = 8'($urandom);
    endtask

    task automatic pulseEvent();
        bus.code_phase_done_in = 1'b1;
        step(1);
        bus.code_phase_done_in = 1'b0;
    endtask

    // Write transaction: data byte follows the command after 'gap' clocks
    task automatic doWrite(input logic [6:0] a, input logic [7:0] d, input int gap);
        applyStimulus({1'b0, a});
        if (gap > 1) step(gap - 1);
        applyStimulus(d);
        if (a < 8) begin
            exp_wr++;
            exp_mem[a[2:0]] = d;
        end
        step(SETTLE);
        checkOutput("wr_count", wr_cnt, exp_wr);
        if (a < 8) begin
            checkOutput("wr_addr", 32'(last_wr_addr), 32'(a));
            checkOutput("wr_data", 32'(last_wr_data), 32'(d));
        end
        checkOutput("wr_no_timeout", to_cnt, exp_to);
    endtask

    task automatic doRead(input logic [6:0] a);
        logic [7:0] expb;
        applyStimulus({1'b1, a});
        if (a < 8) begin
            exp_rd++;
            expb = exp_mem[a[2:0]];
        end else begin
            expb = 8'h00;
        end
        exp_tx++;
        step(SETTLE);
        checkOutput("rd_count", rd_cnt, exp_rd);
        checkOutput("rd_tx_count", tx_cnt, exp_tx);
        checkOutput("rd_tx_byte", 32'(last_tx_byte), 32'(expb));
        if (a < 8) checkOutput("rd_addr", 32'(last_rd_addr), 32'(a));
    endtask

    task automatic doTimeout(input logic [6:0] a);
        applyStimulus({1'b0, a});
        step(TB_TIMEOUT - 1);
        checkOutput("timeout_not_early", to_cnt, exp_to);
        step(4);
        exp_to++;
        checkOutput("timeout_pulse", to_cnt, exp_to);
        checkOutput("timeout_no_write", wr_cnt, exp_wr);
        step(4);
    endtask

    initial begin
        logic [6:0] ra;
        logic [7:0] rd;
        int         kind;
        int         waited;

        rst_in = 1'b1;
        bus.rx_valid_in = 1'b0;
        bus.rx_data_in = 8'h00;
        bus.code_phase_done_in = 1'b0;
        step(3);
        checkOutput("reset_tx_data", 32'(bus.tx_data_out), 32'h00);
        checkOutput("reset_strobes", {28'h0, bus.reg_wr_out, bus.reg_rd_out, bus.tx_start_out, bus.timeout_out}, 32'h0);
        rst_in = 1'b0;
        step(2);

        // Basic write and read-back
        doWrite(7'h03, 8'h5A, 1);
        doWrite(7'h05, 8'hBA, 2);
        doRead(7'h05);
        checkOutput("rd_latency_ge3", 32'((last_tx_cyc - cmd_cyc) >= 3), 32'h1);

        // Timeout and the last-allowed-cycle boundary
        doTimeout(7'h02);
        doWrite(7'h04, 8'hC3, TB_TIMEOUT);

        // Out-of-range read and write
        doRead(7'h0A);
        checkOutput("oor_tx_data", 32'(bus.tx_data_out), 32'h00);
        doWrite(7'h0A, 8'h11, 1);

        // Overrun during TX_WAIT with the transmitter busy
        busy_len = 8;
        applyStimulus(8'h81);
        exp_rd++;
        exp_tx++;
        waited = 0;
        while (tx_cnt != exp_tx && waited < 20) begin
            step(1);
            waited++;
        end
        checkOutput("overrun_tx_seen", tx_cnt, exp_tx);
        applyStimulus(8'h01);
        exp_drop++;
        busy_len = 0;
        step(TB_TIMEOUT + SETTLE);
        checkOutput("overrun_drop", drop_cnt, exp_drop);
        checkOutput("overrun_no_write", wr_cnt, exp_wr);
        checkOutput("overrun_rd_count", rd_cnt, exp_rd);
        checkOutput("overrun_no_timeout", to_cnt, exp_to);
        checkOutput("overrun_tx_byte", 32'(last_tx_byte), 32'(exp_mem[1]));

        // Events during a read response
        applyStimulus(8'h85);
        pulseEvent();
        step(1);
        pulseEvent();
        step(1);
        pulseEvent();
        exp_rd++;
`ifdef EVENT_NOTIFY_EN
        exp_tx += 2;
        step(2 * SETTLE);
        checkOutput("evt_tx_count", tx_cnt, exp_tx);
        checkOutput("evt_read_first", 32'(prev_tx_byte), 32'(exp_mem[5]));
        checkOutput("evt_byte", 32'(last_tx_byte), 32'hE5);
`else
        exp_tx += 1;
        step(2 * SETTLE);
        checkOutput("evt_tx_count", tx_cnt, exp_tx);
        checkOutput("evt_read_byte", 32'(last_tx_byte), 32'(exp_mem[5]));
`endif
        checkOutput("evt_rd_count", rd_cnt, exp_rd);

        // Lone event while idle
        pulseEvent();
`ifdef EVENT_NOTIFY_EN
        exp_tx++;
        step(SETTLE);
        checkOutput("evt_idle_byte", 32'(last_tx_byte), 32'hE5);
`else
        step(SETTLE);
`endif
        checkOutput("evt_idle_count", tx_cnt, exp_tx);

        // Reset in the middle of a write and of a read
        applyStimulus(8'h03);
        step(2);
        rst_in = 1'b1;
        step(2);
        rst_in = 1'b0;
        step(TB_TIMEOUT + 4);
        checkOutput("rst_wr_no_write", wr_cnt, exp_wr);
        checkOutput("rst_wr_no_timeout", to_cnt, exp_to);
        applyStimulus(8'h83);
        exp_rd++;
        step(1);
        rst_in = 1'b1;
        step(2);
        rst_in = 1'b0;
        step(SETTLE);
        checkOutput("rst_rd_no_tx", tx_cnt, exp_tx);
        checkOutput("rst_rd_tx_data", 32'(bus.tx_data_out), 32'h00);

        // Random register traffic
        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 4));
            ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(8, 127)) : 7'($urandom_range(0, 7));
            rd = 8'($urandom);
            case (kind)
                0, 1:    doWrite(ra, rd, int'($urandom_range(1, 6)));
                2, 3:    doRead(ra);
                default: doTimeout(7'($urandom_range(0, 7)));
            endcase
        end

        checkOutput("final_drop", drop_cnt, exp_drop);
        checkOutput("final_tx_count", tx_cnt, exp_tx);
        checkOutput("strobe_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
